// File: rtl/address_unit_pkg.sv
// ============================================================================
// address_unit_pkg : address_select source codes shared with the control unit
// Revision 1.0
// ============================================================================
`default_nettype none

package address_unit_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] SEL_PC         = 3'b000;
  localparam logic [2:0] SEL_ZERO       = 3'b001;
  localparam logic [2:0] SEL_ABS        = 3'b010;
  localparam logic [2:0] SEL_IND_ZERO_0 = 3'b011;
  localparam logic [2:0] SEL_IND_ZERO_1 = 3'b100;
  localparam logic [2:0] SEL_IND_ABS_0  = 3'b101;
  localparam logic [2:0] SEL_IND_ABS_1  = 3'b110;

endpackage

`default_nettype wire

// File: rtl/address_unit_reg8_load.sv
// ============================================================================
// reg8_load : 8-bit register with load enable and asynchronous reset to zero
// Revision 1.0
// ============================================================================
`default_nettype none

module reg8_load (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] d_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) q_d = d_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 8'h00;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/address_unit.sv
// ============================================================================
// address_unit : PC, direct/indirect address latches and memory address mux
// Revision 1.0
// ============================================================================
`default_nettype none

module address_unit
  import address_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter bit          ZP_WRAP  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        increment_pc_i,
  input  logic        pc_load_i,
  input  logic        indirl_load_i,
  input  logic        indirh_load_i,
  input  logic        dirl_load_i,
  input  logic        dirh_load_i,
  input  logic [2:0]  address_select_i,
  input  logic [7:0]  alu_result_i,
  output logic [15:0] address_o,
  output logic [15:0] pc_o,
  output logic [15:0] dir_addr_o
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic [7:0]  dirl_q;
  logic [7:0]  dirh_q;
  logic [7:0]  indirl_q;
  logic [7:0]  indirh_q;
  logic [8:0]  zp_next;
  logic [15:0] ind_zero_1;
  logic [15:0] ind_abs_1;

  reg8_load u_dirl (
    .clk    (clk),
    .rst    (rst),
    .load_i (dirl_load_i),
    .d_i    (alu_result_i),
    .q_o    (dirl_q)
  );

  reg8_load u_dirh (
    .clk    (clk),
    .rst    (rst),
    .load_i (dirh_load_i),
    .d_i    (alu_result_i),
    .q_o    (dirh_q)
  );

  reg8_load u_indirl (
    .clk    (clk),
    .rst    (rst),
    .load_i (indirl_load_i),
    .d_i    (alu_result_i),
    .q_o    (indirl_q)
  );

  reg8_load u_indirh (
    .clk    (clk),
    .rst    (rst),
    .load_i (indirh_load_i),
    .d_i    (alu_result_i),
    .q_o    (indirh_q)
  );

  // Jump load takes priority over sequential fetch increment.
  always_comb begin
    pc_d = pc_q;
    if (pc_load_i)           pc_d = {dirh_q, dirl_q};
    else if (increment_pc_i) pc_d = pc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC;
    else     pc_q <= pc_d;
  end

  // Second pointer byte: either stays in page 0 or carries into 0x0100.
  assign zp_next    = {1'b0, indirl_q} + 9'd1;
  assign ind_zero_1 = ZP_WRAP ? {8'h00, zp_next[7:0]} : {7'h00, zp_next};
  assign ind_abs_1  = {indirh_q, indirl_q} + 16'd1;

  always_comb begin
    address_o = pc_q;
    case (address_select_i)
      SEL_PC:         address_o = pc_q;
      SEL_ZERO:       address_o = {8'h00, dirl_q};
      SEL_ABS:        address_o = {dirh_q, dirl_q};
      SEL_IND_ZERO_0: address_o = {8'h00, indirl_q};
      SEL_IND_ZERO_1: address_o = ind_zero_1;
      SEL_IND_ABS_0:  address_o = {indirh_q, indirl_q};
      SEL_IND_ABS_1:  address_o = ind_abs_1;
      default:        address_o = pc_q;
    endcase
  end

  assign pc_o       = pc_q;
  assign dir_addr_o = {dirh_q, dirl_q};

endmodule

`default_nettype wire

// File: tb/tb_address_unit.sv
// ============================================================================
// tb_address_unit : directed vectors with a queued scoreboard for address_unit
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_address_unit;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] dir;
    logic [15:0] addr_nw;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        inc;
  logic        pcl;
  logic        il_ld;
  logic        ih_ld;
  logic        dl_ld;
  logic        dh_ld;
  logic [2:0]  sel;
  logic [7:0]  alu;
  logic [15:0] addr;
  logic [15:0] pc;
  logic [15:0] dir;
  logic [15:0] addr_nw;
  logic [15:0] pc_nw;
  logic [15:0] dir_nw;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  address_unit #(.RESET_PC(16'hC000), .ZP_WRAP(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .increment_pc_i   (inc),
    .pc_load_i        (pcl),
    .indirl_load_i    (il_ld),
    .indirh_load_i    (ih_ld),
    .dirl_load_i      (dl_ld),
    .dirh_load_i      (dh_ld),
    .address_select_i (sel),
    .alu_result_i     (alu),
    .address_o        (addr),
    .pc_o             (pc),
    .dir_addr_o       (dir)
  );

  address_unit #(.RESET_PC(16'hC000), .ZP_WRAP(1'b0)) dut_nw (
    .clk              (clk),
    .rst              (rst),
    .increment_pc_i   (inc),
    .pc_load_i        (pcl),
    .indirl_load_i    (il_ld),
    .indirh_load_i    (ih_ld),
    .dirl_load_i      (dl_ld),
    .dirh_load_i      (dh_ld),
    .address_select_i (sel),
    .alu_result_i     (alu),
    .address_o        (addr_nw),
    .pc_o             (pc_nw),
    .dir_addr_o       (dir_nw)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one entry is consumed per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("address", addr, e.addr);
        chk("pc", pc, e.pc);
        chk("dir_addr", dir, e.dir);
        chk("address_nowrap", addr_nw, e.addr_nw);
      end
    end
  end

  // ld bits: [0]=dirl [1]=dirh [2]=indirl [3]=indirh
  task automatic cyc(input logic r, input logic [2:0] s, input logic i, input logic p,
                     input logic [3:0] ld, input logic [7:0] a,
                     input logic [15:0] ea, input logic [15:0] ep,
                     input logic [15:0] ed, input logic [15:0] en);
    exp_t e;
    @(posedge clk);
    #1;
    rst   = r;
    sel   = s;
    inc   = i;
    pcl   = p;
    dl_ld = ld[0];
    dh_ld = ld[1];
    il_ld = ld[2];
    ih_ld = ld[3];
    alu   = a;
    e.addr    = ea;
    e.pc      = ep;
    e.dir     = ed;
    e.addr_nw = en;
    exp_q.push_back(e);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0; inc = 1'b0; pcl = 1'b0; sel = 3'd0; alu = 8'h00;
    il_ld = 1'b0; ih_ld = 1'b0; dl_ld = 1'b0; dh_ld = 1'b0;
    #1 rst = 1'b1;

    // Reset holds PC even with increment requested
    cyc(1, 3'b000, 1, 0, 4'b0000, 8'h00, 16'hC000, 16'hC000, 16'h0000, 16'hC000);
    cyc(1, 3'b000, 1, 0, 4'b0000, 8'h00, 16'hC000, 16'hC000, 16'h0000, 16'hC000);
    // Build FFFE in dir, jump there, then increment across the wrap
    cyc(0, 3'b000, 0, 0, 4'b0001, 8'hFE, 16'hC000, 16'hC000, 16'h0000, 16'hC000);
    cyc(0, 3'b001, 0, 0, 4'b0010, 8'hFF, 16'h00FE, 16'hC000, 16'h00FE, 16'h00FE);
    cyc(0, 3'b010, 0, 1, 4'b0000, 8'h00, 16'hFFFE, 16'hC000, 16'hFFFE, 16'hFFFE);
    cyc(0, 3'b000, 1, 0, 4'b0000, 8'h00, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE);
    cyc(0, 3'b000, 1, 0, 4'b0000, 8'h00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF);
    cyc(0, 3'b000, 1, 0, 4'b0000, 8'h00, 16'h0000, 16'h0000, 16'hFFFE, 16'h0000);
    // Zero page, with same-cycle load/select showing the old value
    cyc(0, 3'b000, 0, 0, 4'b0001, 8'h85, 16'h0001, 16'h0001, 16'hFFFE, 16'h0001);
    cyc(0, 3'b001, 0, 0, 4'b0001, 8'h34, 16'h0085, 16'h0001, 16'hFF85, 16'h0085);
    cyc(0, 3'b001, 0, 0, 4'b0010, 8'h12, 16'h0034, 16'h0001, 16'hFF34, 16'h0034);
    // Absolute, and pc_load beats increment_pc
    cyc(0, 3'b010, 1, 1, 4'b0000, 8'h00, 16'h1234, 16'h0001, 16'h1234, 16'h1234);
    cyc(0, 3'b000, 0, 0, 4'b0100, 8'hFF, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    // Indirect zero page: wrap vs carry
    cyc(0, 3'b011, 0, 0, 4'b0000, 8'h00, 16'h00FF, 16'h1234, 16'h1234, 16'h00FF);
    cyc(0, 3'b100, 0, 0, 4'b0000, 8'h00, 16'h0000, 16'h1234, 16'h1234, 16'h0100);
    // Indirect absolute with carry into high byte
    cyc(0, 3'b101, 0, 0, 4'b1000, 8'h10, 16'h00FF, 16'h1234, 16'h1234, 16'h00FF);
    cyc(0, 3'b101, 0, 0, 4'b0000, 8'h00, 16'h10FF, 16'h1234, 16'h1234, 16'h10FF);
    cyc(0, 3'b110, 0, 0, 4'b0000, 8'h00, 16'h1100, 16'h1234, 16'h1234, 16'h1100);
    cyc(0, 3'b111, 0, 0, 4'b0000, 8'h00, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    // FFFF + 1 wraps to 0000
    cyc(0, 3'b110, 0, 0, 4'b1000, 8'hFF, 16'h1100, 16'h1234, 16'h1234, 16'h1100);
    cyc(0, 3'b110, 0, 0, 4'b0000, 8'h00, 16'h0000, 16'h1234, 16'h1234, 16'h0000);
    // All four latches loaded in one cycle
    cyc(0, 3'b010, 0, 0, 4'b1111, 8'h5A, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    cyc(0, 3'b101, 0, 0, 4'b0000, 8'h00, 16'h5A5A, 16'h1234, 16'h5A5A, 16'h5A5A);
    cyc(0, 3'b110, 1, 0, 4'b0000, 8'h00, 16'h5A5B, 16'h1234, 16'h5A5A, 16'h5A5B);
    // Mid-operation reset takes effect within the same cycle
    cyc(1, 3'b110, 1, 0, 4'b0000, 8'h00, 16'h0001, 16'hC000, 16'h0000, 16'h0001);
    cyc(1, 3'b101, 0, 0, 4'b0000, 8'h00, 16'h0000, 16'hC000, 16'h0000, 16'h0000);
    cyc(0, 3'b000, 1, 0, 4'b0000, 8'h00, 16'hC000, 16'hC000, 16'h0000, 16'hC000);
    cyc(0, 3'b000, 0, 0, 4'b0000, 8'h00, 16'hC001, 16'hC001, 16'h0000, 16'hC001);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
